// File: rtl/maxpool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_ctrl
// Purpose  : 2x2 stride-2 max-pooling sequencer over a square map in RAM.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_ctrl #(
    parameter  int DATA_W     = 16,
    parameter  int IN_DIM     = 28,
    parameter  int SIGNED_CMP = 0,
    localparam int OUT_DIM    = IN_DIM / 2,
    localparam int AW         = $clog2(IN_DIM * IN_DIM),
    localparam int OW         = (OUT_DIM > 1) ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [OW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    localparam int RC_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [RC_W-1:0] C_RC_LAST = RC_W'(OUT_DIM - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAST = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [RC_W-1:0]   row_q,     row_d;
    logic [RC_W-1:0]   col_q,     col_d;
    logic [1:0]        rd_cnt_q,  rd_cnt_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              rd_en_q,   rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              wr_en_q,   wr_en_d;
    logic [OW-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [DATA_W-1:0] max_w;
    logic [RC_W-1:0]   row_nxt_w;
    logic [RC_W-1:0]   col_nxt_w;
    logic              last_win_w;

    // Strict greater-than so that an equal later sample never replaces acc.
    function automatic logic sample_gt(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // idx[0] selects the right column, idx[1] the lower row of the window.
    function automatic logic [AW-1:0] win_addr(input logic [RC_W-1:0] row,
                                               input logic [RC_W-1:0] col,
                                               input logic [1:0]      idx);
        int a;
        a = 2 * IN_DIM * int'(row) + 2 * int'(col)
            + (idx[0] ? 1 : 0) + (idx[1] ? IN_DIM : 0);
        return AW'(a);
    endfunction

    always_comb begin
        max_w      = sample_gt(rd_data, acc_q) ? rd_data : acc_q;
        last_win_w = (row_q == C_RC_LAST) && (col_q == C_RC_LAST);
        if (col_q == C_RC_LAST) begin
            col_nxt_w = '0;
            row_nxt_w = row_q + RC_W'(1);
        end else begin
            col_nxt_w = col_q + RC_W'(1);
            row_nxt_w = row_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        rd_cnt_d  = rd_cnt_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d     = '0;
                    col_d     = '0;
                    rd_cnt_d  = 2'd0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = win_addr('0, '0, 2'd0);
                    state_d   = S_RD;
                end
            end

            S_RD: begin
                // Read data trails its strobe by one cycle: sample 0 lands
                // while the second address is on the bus.
                if (rd_cnt_q == 2'd1) begin
                    acc_d = rd_data;
                end else if (rd_cnt_q != 2'd0) begin
                    acc_d = max_w;
                end
                if (rd_cnt_q == 2'd3) begin
                    rd_en_d = 1'b0;
                    state_d = S_LAST;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 2'd1;
                    rd_addr_d = win_addr(row_q, col_q, rd_cnt_q + 2'd1);
                end
            end

            S_LAST: begin
                acc_d     = max_w;
                wr_en_d   = 1'b1;
                wr_addr_d = OW'(int'(row_q) * OUT_DIM + int'(col_q));
                wr_data_d = max_w;
                state_d   = S_WR;
            end

            S_WR: begin
                if (wr_ready) begin
                    wr_en_d = 1'b0;
                    if (last_win_w) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        row_d     = row_nxt_w;
                        col_d     = col_nxt_w;
                        rd_cnt_d  = 2'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = win_addr(row_nxt_w, col_nxt_w, 2'd0);
                        state_d   = S_RD;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            rd_cnt_q  <= 2'd0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_cnt_q  <= rd_cnt_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_ctrl
// Purpose  : Scoreboard bench for maxpool_ctrl, unsigned and signed instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_ctrl;

    logic clk = 1'b0;
    logic rst, start, wr_ready;

    logic        u_busy, u_done, u_rd_en, u_wr_en;
    logic [9:0]  u_rd_addr;
    logic [7:0]  u_wr_addr;
    logic [15:0] u_wr_data, u_rd_data;
    logic        s_busy, s_done, s_rd_en, s_wr_en;
    logic [9:0]  s_rd_addr;
    logic [7:0]  s_wr_addr;
    logic [15:0] s_wr_data, s_rd_data;

    logic [15:0] mem [0:783];
    logic [23:0] sb_u [$];
    logic [23:0] sb_s [$];
    logic [9:0]  rd_q [$];

    int checks = 0, errors = 0;
    int ecnt = 0, ref_e = 0, exp_done = 0;
    int wr_idx = 0, done_cnt_u = 0, done_cnt_s = 0;
    bit mon_on = 0, quiet = 0, first_rd = 0, wr_prev = 0;
    logic [9:0] last_addr = '0;

    maxpool_ctrl #(.DATA_W(16), .IN_DIM(28), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .busy(u_busy), .done(u_done),
        .rd_en(u_rd_en), .rd_addr(u_rd_addr), .rd_data(u_rd_data),
        .wr_en(u_wr_en), .wr_addr(u_wr_addr), .wr_data(u_wr_data),
        .wr_ready(wr_ready));

    maxpool_ctrl #(.DATA_W(16), .IN_DIM(28), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .wr_ready(wr_ready));

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    initial begin
        u_rd_data = '0;
        s_rd_data = '0;
    end
    always @(posedge clk) begin
        if (u_rd_en) u_rd_data <= mem[u_rd_addr];
        if (s_rd_en) s_rd_data <= mem[s_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pool4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d,
                                          input bit sg);
        logic [15:0] v [4];
        logic [15:0] m;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        m = v[0];
        for (int i = 1; i < 4; i++) begin
            if (sg ? ($signed(v[i]) > $signed(m)) : (v[i] > m)) m = v[i];
        end
        return m;
    endfunction

    // mode 0: closed-form ramp results; 1: model over mem; 2: model with literal windows 0/1
    task automatic start_map(input int mode, input int edone);
        int b;
        logic [15:0] eu, es;
        ref_e    = ecnt;
        exp_done = edone;
        wr_idx   = 0;
        first_rd = 1;
        start    = 1'b1;
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                b = 2 * r * 28 + 2 * c;
                rd_q.push_back(10'(b));
                rd_q.push_back(10'(b + 1));
                rd_q.push_back(10'(b + 28));
                rd_q.push_back(10'(b + 29));
                if (mode == 0) begin
                    eu = 16'((2 * r + 1) * 28 + 2 * c + 1);
                    es = eu;
                end else if (mode == 2 && r == 0 && c == 0) begin
                    eu = 16'hFFFF;
                    es = 16'h7FFF;
                end else if (mode == 2 && r == 0 && c == 1) begin
                    eu = 16'h0005;
                    es = 16'h0005;
                end else begin
                    eu = pool4(mem[b], mem[b + 1], mem[b + 28], mem[b + 29], 1'b0);
                    es = pool4(mem[b], mem[b + 1], mem[b + 28], mem[b + 29], 1'b1);
                end
                sb_u.push_back({8'(r * 14 + c), eu});
                sb_s.push_back({8'(r * 14 + c), es});
            end
        end
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while ((ecnt - ref_e) < c && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        int cyc;
        #1;
        if (mon_on) begin
            cyc = ecnt - ref_e;
            check("rd_wr_overlap", {63'd0, u_rd_en & u_wr_en}, 64'd0);
            if (quiet) begin
                check("quiet_u", {u_busy, u_done, u_rd_en, u_wr_en, u_rd_addr, u_wr_addr, u_wr_data}, 64'd0);
                check("quiet_s", {s_busy, s_done, s_rd_en, s_wr_en, s_rd_addr, s_wr_addr, s_wr_data}, 64'd0);
            end else begin
                if (u_rd_en) begin
                    if (first_rd) begin
                        check("first_rd_cycle", 64'(cyc), 64'd1);
                        first_rd = 0;
                    end
                    check("rd_q_nonempty", {63'd0, rd_q.size() != 0}, 64'd1);
                    if (rd_q.size() != 0) begin
                        last_addr = rd_q.pop_front();
                        check("rd_addr", 64'(u_rd_addr), 64'(last_addr));
                    end
                end else begin
                    check("rd_addr_hold", 64'(u_rd_addr), 64'(last_addr));
                end
                if (u_wr_en) begin
                    if (!wr_prev && wr_idx == 0) check("first_wr_cycle", 64'(cyc), 64'd6);
                    check("sb_u_nonempty", {63'd0, sb_u.size() != 0}, 64'd1);
                    if (sb_u.size() != 0) begin
                        check("wr_u", 64'({u_wr_addr, u_wr_data}), 64'(sb_u[0]));
                        if (wr_ready) begin
                            void'(sb_u.pop_front());
                            wr_idx++;
                        end
                    end
                end
                if (s_wr_en) begin
                    check("sb_s_nonempty", {63'd0, sb_s.size() != 0}, 64'd1);
                    if (sb_s.size() != 0) begin
                        check("wr_s", 64'({s_wr_addr, s_wr_data}), 64'(sb_s[0]));
                        if (wr_ready) void'(sb_s.pop_front());
                    end
                end
                if (u_done) begin
                    done_cnt_u++;
                    check("done_cycle", 64'(cyc), 64'(exp_done));
                    check("done_busy", {63'd0, u_busy}, 64'd0);
                end
                if (s_done) done_cnt_s++;
            end
            wr_prev = u_wr_en;
        end
    end

    task automatic end_of_map(input int n_done);
        check("sb_u_empty", 64'(sb_u.size()), 64'd0);
        check("sb_s_empty", 64'(sb_s.size()), 64'd0);
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        check("done_cnt_u", 64'(done_cnt_u), 64'(n_done));
        check("done_cnt_s", 64'(done_cnt_s), 64'(n_done));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 784; i++) mem[i] = 16'(i);
        repeat (3) @(negedge clk);
        check("reset_u", {u_busy, u_done, u_rd_en, u_wr_en, u_rd_addr, u_wr_addr, u_wr_data}, 64'd0);
        check("reset_s", {s_busy, s_done, s_rd_en, s_wr_en, s_rd_addr, s_wr_addr, s_wr_data}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_on = 1;

        // Ramp map, spurious starts at 50 and in FIN, restart right after done.
        start_map(0, 1177);
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", {63'd0, u_busy}, 64'd1);
        goto(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        goto(1177);
        start = 1'b1;
        @(negedge clk);
        end_of_map(1);

        // Back-to-back map with a 7-cycle write stall on window 3.
        start_map(0, 1184);
        @(negedge clk);
        start = 1'b0;
        goto(24);
        wr_ready = 1'b0;
        goto(31);
        wr_ready = 1'b1;
        goto(1186);
        end_of_map(2);

        // Random data with a signedness-sensitive window and an all-equal window.
        for (int i = 0; i < 784; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hFFFF; mem[1] = 16'h8000; mem[28] = 16'h0003; mem[29] = 16'h7FFF;
        mem[2] = 16'h0005; mem[3] = 16'h0005; mem[30] = 16'h0005; mem[31] = 16'h0005;
        start_map(2, 1177);
        @(negedge clk);
        start = 1'b0;
        goto(1179);
        end_of_map(3);

        // Reset mid-map abandons it.
        start_map(1, 1177);
        @(negedge clk);
        start = 1'b0;
        goto(500);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        sb_u.delete();
        sb_s.delete();
        rd_q.delete();
        last_addr = '0;
        repeat (100) @(negedge clk);
        check("done_cnt_after_rst", 64'(done_cnt_u), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool_ctrl.md
MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the feature-map element width in bits.
REQ-002 SHALL have parameter IN_DIM, default 28, giving the input map side length; it must be even, and OUT_DIM = IN_DIM/2.
REQ-003 SHALL have parameter SIGNED_CMP, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to pool one full map.
REQ-007 SHALL have port busy, output, 1 bit: high while a map is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse when a map completes.
REQ-009 SHALL have port rd_en, output, 1 bit: input-RAM read strobe.
REQ-010 SHALL have port rd_addr, output, clog2(IN_DIM*IN_DIM) bits (10 at default): row-major element index of the input map.
REQ-011 SHALL have port rd_data, input, DATA_W bits: read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port wr_en, output, 1 bit: output-RAM write request.
REQ-013 SHALL have port wr_addr, output, clog2(OUT_DIM*OUT_DIM) bits (8 at default): row-major pooled index.
REQ-014 SHALL have port wr_data, output, DATA_W bits: the pooled maximum.
REQ-015 SHALL have port wr_ready, input, 1 bit: a write is accepted in a cycle where wr_en and wr_ready are both high.

Function
REQ-016 SHALL drive all outputs from registers; there are no combinational input-to-output paths.
REQ-017 SHALL implement FSM states IDLE, RD, LAST, WR, FIN.
REQ-018 SHALL, in IDLE, sample start=1, load window row r=0 and col c=0, and enter RD next cycle with busy=1.
REQ-019 SHALL, in RD, issue exactly 4 consecutive rd_en cycles with addresses in this order: (2r)*IN_DIM+2c, +1, +IN_DIM, +IN_DIM+1; then enter LAST.
REQ-020 SHALL load the running max with the first returned rd_data and update it as max(acc, rd_data) for each later sample.
REQ-021 SHALL keep acc on equal values, i.e. the earlier sample wins ties.
REQ-022 SHALL, in LAST (rd_en=0), fold in the 4th sample and register wr_en=1, wr_addr=r*OUT_DIM+c, and wr_data=final max; then enter WR.
REQ-023 SHALL, in WR, hold wr_en, wr_addr, and wr_data stable until wr_ready=1.
REQ-024 SHALL, on write acceptance, deassert wr_en next cycle and advance c (at c=OUT_DIM-1: c wraps to 0 and r increments).
REQ-025 SHALL, after acceptance of window (OUT_DIM-1, OUT_DIM-1), go to FIN instead of RD.
REQ-026 SHALL return to RD on acceptance of any other window.
REQ-027 SHALL, in FIN, assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-028 SHALL give a window period of 6 cycles with wr_ready held high.
REQ-029 SHALL, with a start sampled in cycle 0, issue window k reads in cycles 1+6k..4+6k and assert its wr_en in cycle 6+6k.
REQ-030 SHALL, at default parameters with wr_ready high, place the final write in cycle 1176 and done in cycle 1177.
REQ-031 SHALL delay all later activity one-for-one by any wr_ready=0 stall cycles.
REQ-032 SHALL ignore start while busy=1 or in FIN, with no queuing.
REQ-033 SHALL accept a start in the cycle after done.
REQ-034 SHALL keep rd_en=0 whenever it is not in RD.
REQ-035 SHALL never assert rd_en and wr_en in the same cycle.
REQ-036 SHALL hold rd_addr at its last value when rd_en=0.
REQ-037 SHALL perform the compare at DATA_W bits with no widening or saturation, using signedness per SIGNED_CMP.

Reset
REQ-038 SHALL, when rst=1 at a clock edge, force the state to IDLE, r=c=0, acc=0, and outputs busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-039 SHALL give rst priority over start and wr_ready.
REQ-040 SHALL, on reset mid-map (including a pending WR), abandon the map: no further reads or writes occur and no done is generated.

Verification
REQ-041 SHALL pass this scenario:
- Stimulus: input RAM element i = i (unsigned), wr_ready=1, start pulsed once.
- Response: 196 writes, window (r,c) yields wr_data=(2r+1)*28+2c+1.
- Response: write 0 carries value 29 at cycle 6; done at cycle 1177 only.
REQ-042 SHALL pass this scenario:
- Stimulus: SIGNED_CMP=1, window 0 = {0xFFFF, 0x8000, 0x0003, 0x7FFF}.
- Response: wr_data=0x7FFF; SIGNED_CMP=0 gives 0xFFFF instead.
REQ-043 SHALL pass this scenario:
- Stimulus: all-equal window {0x0005 x4}.
- Response: wr_data=0x0005.
REQ-044 SHALL pass this scenario:
- Stimulus: wr_ready held 0 for 7 cycles on window 3.
- Response: wr_en, wr_addr=3, and wr_data stay stable; no rd_en during the stall; done moves to cycle 1184.
REQ-045 SHALL pass this scenario:
- Stimulus: start re-pulsed at cycles 50 and 1177.
- Response: the cycle-50 pulse is ignored; the cycle-1177 pulse is ignored (FIN); a start at cycle 1178 begins a new map with first rd_en at cycle 1179.
REQ-046 SHALL pass this scenario:
- Stimulus: rst=1 for one cycle at cycle 500.
- Response: from cycle 501 all outputs are 0, with no done or wr_en afterwards until a new start.
